// File: rtl/pb_keycode_encoder_pkg.sv
// Shared types for the push-button key-code encoder: FSM state encoding and
// key-code width for the 20-button front panel.
package pb_enc_pkg;
  localparam int NKEYS_DEF = 20;
  localparam int KW        = $clog2(NKEYS_DEF);

  typedef enum logic [1:0] {IDLE, ARM, HELD, REL} pbenc_state_t;
  typedef logic [KW-1:0] keycode_t;
endpackage

// File: rtl/pb_keycode_encoder_prio_enc.sv
// Combinational priority encoder: index of the highest set request bit,
// zero when nothing is set (qualify with any).
module prio_enc #(
  parameter int N = 20,
  localparam int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic [CW-1:0] code,
  output logic          any
);

  always_comb begin
    code = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) code = CW'(i);
    end
    any = |req;
  end

endmodule

// File: rtl/pb_keycode_encoder.sv
// Debounced, priority-encoded key events from raw push-button levels, with a
// code history shift register and a wrapping press counter.
module pb_keycode_encoder
  import pb_enc_pkg::*;
#(
  parameter int NKEYS    = 20,
  parameter int DEBOUNCE = 2,
  parameter int DIGITS   = 8
) (
  input  logic                 hz100,
  input  logic                 reset,
  input  logic [NKEYS-1:0]     pb,
  output logic [KW-1:0]        keycode,
  output logic                 strobe,
  output logic                 valid,
  output logic [DIGITS*KW-1:0] history,
  output logic [7:0]           press_count,
  output logic                 busy
);

  localparam int CNTW = $clog2(DEBOUNCE) + 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DEBOUNCE - 1);

  logic [NKEYS-1:0] pb_p0;
  logic [NKEYS-1:0] pb_p1;
  keycode_t         enc_s;
  logic             any_s;
  pbenc_state_t     state;
  logic [CNTW-1:0]  cnt;
  keycode_t         cand;

  // Stage p0/p1: two-flop synchroniser for the asynchronous button levels
  always_ff @(posedge hz100) begin
    if (reset) begin
      pb_p0 <= '0;
      pb_p1 <= '0;
    end else begin
      pb_p0 <= pb;
      pb_p1 <= pb_p0;
    end
  end

  prio_enc #(.N(NKEYS)) u_prio_enc (
    .req  (pb_p1),
    .code (enc_s),
    .any  (any_s)
  );

  // Debounce FSM; event outputs are registered on the accepting edge
  always_ff @(posedge hz100) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      cand        <= '0;
      keycode     <= '0;
      strobe      <= 1'b0;
      valid       <= 1'b0;
      history     <= '0;
      press_count <= '0;
    end else begin
      strobe <= 1'b0;
      case (state)
        IDLE: begin
          if (any_s) begin
            cand  <= enc_s;
            cnt   <= '0;
            state <= ARM;
          end
        end
        ARM: begin
          // A changed winning code restarts arming from IDLE with the new code
          if (!any_s || enc_s != cand) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            keycode     <= cand;
            strobe      <= 1'b1;
            valid       <= 1'b1;
            history     <= {history[(DIGITS-1)*KW-1:0], cand};
            press_count <= press_count + 8'd1;
            state       <= HELD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (!any_s) begin
            cnt   <= '0;
            state <= REL;
          end
        end
        REL: begin
          if (any_s) begin
            state <= HELD;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_pb_keycode_encoder.sv
// Bench for pb_keycode_encoder: directed scenarios plus random button traffic,
// checked every cycle against a run-length model of the debounce rules.
module tb_pb_keycode_encoder;
  localparam int NKEYS    = 20;
  localparam int DEBOUNCE = 2;
  localparam int DIGITS   = 8;
  localparam int KW       = 5;

  logic                 hz100 = 1'b0;
  logic                 reset = 1'b1;
  logic [NKEYS-1:0]     pb    = '0;
  logic [KW-1:0]        keycode;
  logic                 strobe;
  logic                 valid;
  logic [DIGITS*KW-1:0] history;
  logic [7:0]           press_count;
  logic                 busy;

  pb_keycode_encoder #(.NKEYS(NKEYS), .DEBOUNCE(DEBOUNCE), .DIGITS(DIGITS)) dut (
    .hz100       (hz100),
    .reset       (reset),
    .pb          (pb),
    .keycode     (keycode),
    .strobe      (strobe),
    .valid       (valid),
    .history     (history),
    .press_count (press_count),
    .busy        (busy)
  );

  always #5 hz100 = ~hz100;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: synchroniser as a two-deep delay, press acceptance as
  // run lengths of a stable winning key and of continuous silence.
  logic [NKEYS-1:0] m_s1 = '0, m_s2 = '0;
  int  m_phase = 0;   // 0 quiet, 1 arming, 2 down, 3 letting go
  int  m_cand = 0, m_run = 0, m_key = 0, m_cnt = 0, mk = 0;
  bit  m_strobe = 0, m_valid = 0, m_live = 0;
  int  m_hist[DIGITS];

  function automatic int top_key(input logic [NKEYS-1:0] v);
    int r = -1;
    for (int i = 0; i < NKEYS; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic logic [NKEYS-1:0] onehot(input int i);
    logic [NKEYS-1:0] r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  always @(posedge hz100) begin
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_phase = 0; m_cand = 0; m_run = 0;
      m_key = 0; m_cnt = 0; m_strobe = 0; m_valid = 0; m_live = 1;
      for (int i = 0; i < DIGITS; i++) m_hist[i] = 0;
    end else begin
      mk = top_key(m_s2);
      m_strobe = 0;
      case (m_phase)
        0: if (mk >= 0) begin m_cand = mk; m_run = 1; m_phase = 1; end
        1: begin
          if (mk != m_cand) m_phase = 0;
          else if (m_run == DEBOUNCE) begin
            m_key = m_cand; m_strobe = 1; m_valid = 1;
            for (int i = DIGITS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = m_cand;
            m_cnt = (m_cnt + 1) % 256;
            m_phase = 2;
          end else m_run++;
        end
        2: if (mk < 0) begin m_phase = 3; m_run = 1; end
        default: begin
          if (mk >= 0) m_phase = 2;
          else if (m_run == DEBOUNCE) m_phase = 0;
          else m_run++;
        end
      endcase
      m_s2 = m_s1;
      m_s1 = pb;
    end
  end

  logic [DIGITS*KW-1:0] m_hvec;
  always @(negedge hz100) begin
    if (m_live) begin
      for (int i = 0; i < DIGITS; i++) m_hvec[i*KW +: KW] = KW'(m_hist[i]);
      chk("keycode", 64'(keycode), 64'(m_key));
      chk("strobe", 64'(strobe), 64'(m_strobe));
      chk("valid", 64'(valid), 64'(m_valid));
      chk("history", 64'(history), 64'(m_hvec));
      chk("press_count", 64'(press_count), 64'(m_cnt));
      chk("busy", 64'(busy), 64'(m_phase != 0));
    end
  end

  task automatic tick();
    @(posedge hz100);
    #1;
  endtask

  task automatic hold(input logic [NKEYS-1:0] v, input int n, output int s);
    pb = v;
    s = 0;
    repeat (n) begin
      tick();
      if (strobe) s++;
    end
  endtask

  int s, s2, tot, key, dur;
  logic [DIGITS*KW-1:0] exp_hist;

  initial begin
    tick(); tick();
    reset = 1'b0;

    hold('0, 20, s);
    chk("idle_strobes", 64'(s), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_valid", 64'(valid), 64'd0);
    chk("idle_count", 64'(press_count), 64'd0);

    pb = onehot(5);
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("pb5_strobe_edge", 64'(strobe), 64'(k == DEBOUNCE + 3));
    end
    chk("pb5_keycode", 64'(keycode), 64'd5);
    chk("pb5_valid", 64'(valid), 64'd1);
    chk("pb5_hist0", 64'(history[KW-1:0]), 64'd5);
    chk("pb5_count", 64'(press_count), 64'd1);
    pb = '0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("rel_busy", 64'(busy), 64'(k < 5));
      chk("rel_strobe", 64'(strobe), 64'd0);
    end

    hold(onehot(3) | onehot(17), 10, s);
    chk("dual_strobes", 64'(s), 64'd1);
    chk("dual_keycode", 64'(keycode), 64'd17);
    hold('0, 8, s);

    tot = 0;
    repeat (12) begin
      hold(onehot(9), 1, s); tot += s;
      hold('0, 1, s); tot += s;
    end
    chk("bounce_strobes", 64'(tot), 64'd0);
    hold('0, 6, s);

    tot = 0;
    hold(onehot(6), 8, s);  tot += s;
    hold('0, 1, s);         tot += s;
    hold(onehot(6), 6, s);  tot += s;
    hold('0, 8, s);         tot += s;
    chk("held_glitch_strobes", 64'(tot), 64'd1);

    reset = 1'b1; tick(); reset = 1'b0;
    tot = 0;
    for (int k = 1; k <= 9; k++) begin
      hold(onehot(k), 8, s); tot += s;
      hold('0, 6, s);        tot += s;
    end
    for (int i = 0; i < DIGITS; i++) exp_hist[i*KW +: KW] = KW'(9 - i);
    chk("seq_strobes", 64'(tot), 64'd9);
    chk("seq_history", 64'(history), 64'(exp_hist));
    chk("seq_count", 64'(press_count), 64'd9);

    tot = 0;
    for (int n = 9; n < 256; n++) begin
      key = $urandom_range(0, NKEYS - 1);
      hold(onehot(key), 8, s); tot += s;
      hold('0, 6, s);          tot += s;
    end
    chk("wrap_strobes", 64'(tot), 64'd247);
    chk("wrap_count", 64'(press_count), 64'd0);

    repeat (300) begin
      dur = $urandom_range(1, 8);
      if ($urandom_range(0, 39) == 0) reset = 1'b1;
      case ($urandom_range(0, 3))
        0: hold('0, dur, s);
        1: hold(onehot($urandom_range(0, NKEYS - 1)), dur, s);
        2: hold(NKEYS'($urandom), dur, s);
        default: hold(onehot($urandom_range(0, NKEYS - 1)) | onehot($urandom_range(0, NKEYS - 1)), dur, s);
      endcase
      reset = 1'b0;
    end

    reset = 1'b1; tick(); reset = 1'b0;
    hold('0, 4, s);
    pb = onehot(12);
    tick(); tick(); tick();
    chk("arm_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    hold(onehot(12), 2, s);
    chk("arm_reset_strobes", 64'(s), 64'd0);
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("post_reset_strobe_edge", 64'(strobe), 64'(k == DEBOUNCE + 3));
    end
    chk("post_reset_keycode", 64'(keycode), 64'd12);
    hold('0, 8, s);

    reset = 1'b1; tick(); reset = 1'b0;
    pb = onehot(7);
    repeat (DEBOUNCE + 2) tick();
    reset = 1'b1;
    tick();
    chk("accept_reset_strobe", 64'(strobe), 64'd0);
    chk("accept_reset_count", 64'(press_count), 64'd0);
    reset = 1'b0;
    hold('0, 6, s);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
